// File: rtl/wb_scrub_master.sv
// wb_scrub_master: Wishbone classic initiator that sweeps a register window,
// reading each word and writing the same value back, with an ack timeout.
module wb_scrub_master #(
   parameter int                      WORD_SIZE    = 32,
   parameter int                      REGISTERS    = 32,
   parameter int                      REGDIRSIZE   = 5,
   parameter int                      WHISBONE_ADR = 32,
   parameter logic [WHISBONE_ADR-1:0] BASE_ADR     = 32'h3000_0000,
   parameter int                      TIMEOUT      = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic                    stop_i,
   output logic                    wbm_cyc_o,
   output logic                    wbm_stb_o,
   output logic                    wbm_we_o,
   output logic [3:0]              wbm_sel_o,
   output logic [WHISBONE_ADR-1:0] wbm_adr_o,
   output logic [WORD_SIZE-1:0]    wbm_dat_o,
   input  logic [WORD_SIZE-1:0]    wbm_dat_i,
   input  logic                    wbm_ack_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o,
   output logic [REGDIRSIZE:0]     words_o
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE} state_t;

   state_t                r_state, w_next;
   logic [REGDIRSIZE-1:0] r_index;
   logic [WORD_SIZE-1:0]  r_data;
   logic [REGDIRSIZE:0]   r_words;
   logic [TW-1:0]         r_tmo;
   logic                  r_stop, r_error;
   logic                  w_stb, w_ack, w_tmo, w_last, w_end;

   assign w_stb  = (r_state == RD) || (r_state == WR);
   assign w_ack  = w_stb && wbm_ack_i;
   assign w_tmo  = w_stb && !wbm_ack_i && (r_tmo == TW'(TIMEOUT - 1));
   assign w_last = r_index == REGDIRSIZE'(REGISTERS - 1);
   // a stop arriving in the same cycle as the write gap still ends the sweep
   assign w_end  = w_last || r_stop || stop_i;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start_i ? RD : IDLE;
         RD:      w_next = w_ack ? RD_GAP : w_tmo ? DONE : RD;
         RD_GAP:  w_next = WR;
         WR:      w_next = w_ack ? WR_GAP : w_tmo ? DONE : WR;
         WR_GAP:  w_next = w_end ? DONE : RD;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_index <= '0;
         r_data  <= '0;
         r_words <= '0;
         r_tmo   <= '0;
         r_stop  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stop  <= (r_state == IDLE) ? (start_i && stop_i) : (r_state == DONE) ? 1'b0 : (r_stop || stop_i);
         // counts only while an access stays pending; any state change clears it
         r_tmo   <= (w_stb && w_next == r_state) ? r_tmo + 1'b1 : '0;
         if (r_state == IDLE && start_i) begin
            r_index <= '0;
            r_words <= '0;
            r_error <= 1'b0;
         end
         if (r_state == RD && w_ack) r_data <= wbm_dat_i;
         if (r_state == WR && w_ack) r_words <= r_words + 1'b1;
         if (w_tmo) r_error <= 1'b1;
         if (r_state == WR_GAP && !w_end) r_index <= r_index + 1'b1;
      end
   end

   assign wbm_cyc_o = w_stb;
   assign wbm_stb_o = w_stb;
   assign wbm_we_o  = r_state == WR;
   assign wbm_sel_o = w_stb ? 4'hF : 4'h0;
   assign wbm_adr_o = w_stb ? BASE_ADR + (WHISBONE_ADR'(r_index) << 2) : '0;
   assign wbm_dat_o = wbm_we_o ? r_data : '0;
   assign busy_o    = (r_state != IDLE) && (r_state != DONE);
   assign done_o    = r_state == DONE;
   assign error_o   = r_error;
   assign words_o   = r_words;
endmodule

// File: tb/tb_wb_scrub_master.sv
// tb_wb_scrub_master: directed scenarios against a behavioural Wishbone
// responder with configurable wait states, missing acks and stray acks.
module tb_wb_scrub_master;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk, rst_n, start, stop;
   logic        cyc, stb, we, ack, busy, done, error;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;
   logic [5:0]  words;

   int          vecs, errs, waits, wcnt, unstable;
   logic        noack, spurious, h_we;
   logic [31:0] h_adr, h_dat;
   logic [31:0] log_adr[$], log_dat[$];
   logic        log_we[$];
   logic [3:0]  log_sel[$];

   wb_scrub_master #(.REGISTERS(4), .TIMEOUT(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
      .busy_o(busy), .done_o(done), .error_o(error), .words_o(words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // responder: answers on the negedge so the DUT samples ack at the next posedge
   initial begin
      ack = 1'b0; dat_i = '0; wcnt = 0;
      forever begin
         @(negedge clk);
         if (cyc && stb) begin
            if (wcnt == 0) begin h_adr = adr; h_we = we; h_dat = dat_o; end
            else if (adr !== h_adr || we !== h_we || dat_o !== h_dat) unstable++;
            if (wcnt >= waits && !(noack && !we && adr == BASE + 32'd8)) begin
               ack = 1'b1;
               dat_i = 32'hA5A5_0000 + ((adr - BASE) >> 2);
               log_adr.push_back(adr); log_we.push_back(we); log_sel.push_back(sel);
               log_dat.push_back(we ? dat_o : dat_i);
               wcnt = 0;
            end else begin
               ack = 1'b0;
               wcnt++;
            end
         end else begin
            ack = spurious;
            wcnt = 0;
         end
      end
   end

   task automatic run_sweep(input int stop_at, input int restart_at, output int n, output logic e0);
      log_adr.delete(); log_we.delete(); log_dat.delete(); log_sel.delete();
      @(negedge clk); start = 1'b1; stop = (stop_at == -2);
      @(negedge clk); start = 1'b0; stop = 1'b0; e0 = error; n = 0;
      while (!done && n < 300) begin
         stop = (n == stop_at); start = (n == restart_at);
         @(negedge clk); n++;
      end
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      vecs++; if ({cyc, stb, we, busy, done, error} !== 6'b0) begin errs++; $display("FAIL reset_ctl got %b want 000000", {cyc, stb, we, busy, done, error}); end
      vecs++; if ({sel, adr, dat_o} !== 68'b0) begin errs++; $display("FAIL reset_bus got sel=%h adr=%h dat=%h want 0", sel, adr, dat_o); end
      vecs++; if (words !== 6'd0) begin errs++; $display("FAIL reset_words got %0d want 0", words); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sweep;
      int n; logic e0;
      run_sweep(-1, -1, n, e0);
      vecs++; if (n !== 16) begin errs++; $display("FAIL sweep_cycles got %0d want 16", n); end
      vecs++; if (e0 !== 1'b0 || error !== 1'b0) begin errs++; $display("FAIL sweep_error got %b/%b want 0/0", e0, error); end
      vecs++; if (words !== 6'd4) begin errs++; $display("FAIL sweep_words got %0d want 4", words); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL sweep_busy_at_done got %b want 0", busy); end
      vecs++; if (log_adr.size() !== 8) begin errs++; $display("FAIL sweep_count got %0d want 8", log_adr.size()); end
      for (int i = 0; i < log_adr.size() && i < 8; i++) begin
         vecs++;
         if (log_adr[i] !== BASE + 32'(4 * (i / 2)) || log_we[i] !== 1'(i % 2) || log_sel[i] !== 4'hF
             || log_dat[i] !== 32'hA5A5_0000 + 32'(i / 2)) begin
            errs++; $display("FAIL sweep_txn%0d got adr=%h we=%b sel=%h dat=%h want adr=%h we=%0d sel=f dat=%h",
                             i, log_adr[i], log_we[i], log_sel[i], log_dat[i], BASE + 32'(4 * (i / 2)), i % 2, 32'hA5A5_0000 + 32'(i / 2));
         end
      end
      @(negedge clk);
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL done_pulse got %b want 0", done); end
   endtask

   task automatic test_wait_states;
      int n; logic e0;
      waits = 3; unstable = 0;
      run_sweep(-1, -1, n, e0);
      vecs++; if (n !== 40) begin errs++; $display("FAIL wait_cycles got %0d want 40", n); end
      vecs++; if (unstable !== 0) begin errs++; $display("FAIL wait_stable got %0d changes want 0", unstable); end
      vecs++; if (words !== 6'd4 || log_adr.size() !== 8) begin errs++; $display("FAIL wait_words got %0d/%0d want 4/8", words, log_adr.size()); end
      waits = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int n; logic e0;
      noack = 1'b1;
      run_sweep(-1, -1, n, e0);
      vecs++; if (n !== 24) begin errs++; $display("FAIL tmo_cycles got %0d want 24", n); end
      vecs++; if (error !== 1'b1 || cyc !== 1'b0) begin errs++; $display("FAIL tmo_flag got err=%b cyc=%b want 1/0", error, cyc); end
      vecs++; if (words !== 6'd2 || log_adr.size() !== 4) begin errs++; $display("FAIL tmo_words got %0d/%0d want 2/4", words, log_adr.size()); end
      noack = 1'b0;
      @(negedge clk);
      vecs++; if (error !== 1'b1) begin errs++; $display("FAIL tmo_sticky got %b want 1", error); end
      run_sweep(-1, -1, n, e0);
      vecs++; if (e0 !== 1'b0 || n !== 16 || words !== 6'd4) begin errs++; $display("FAIL tmo_restart got err=%b n=%0d words=%0d want 0/16/4", e0, n, words); end
      @(negedge clk);
   endtask

   task automatic test_stop;
      int n; logic e0;
      run_sweep(4, -1, n, e0);
      vecs++; if (n !== 8 || words !== 6'd2) begin errs++; $display("FAIL stop_mid got n=%0d words=%0d want 8/2", n, words); end
      vecs++; if (log_adr.size() !== 4 || log_adr[log_adr.size() - 1] !== BASE + 32'd4) begin errs++; $display("FAIL stop_no_word2 got %0d txns want 4 ending at word 1", log_adr.size()); end
      @(negedge clk);
      run_sweep(-2, -1, n, e0);
      vecs++; if (n !== 4 || words !== 6'd1 || log_adr.size() !== 2) begin errs++; $display("FAIL stop_with_start got n=%0d words=%0d txns=%0d want 4/1/2", n, words, log_adr.size()); end
      @(negedge clk);
   endtask

   task automatic test_noise;
      int n; logic e0;
      spurious = 1'b1;
      run_sweep(-1, 5, n, e0);
      vecs++; if (n !== 16 || words !== 6'd4 || log_adr.size() !== 8) begin errs++; $display("FAIL noise got n=%0d words=%0d txns=%0d want 16/4/8", n, words, log_adr.size()); end
      spurious = 1'b0;
      @(negedge clk);
      vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL noise_idle got busy=%b done=%b want 0/0", busy, done); end
   endtask

   task automatic test_reset_mid;
      int n; logic e0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; n = 0;
      while (!(we && adr == BASE + 32'd8) && n < 100) begin @(negedge clk); n++; end
      vecs++; if (n >= 100 || words !== 6'd2) begin errs++; $display("FAIL rst_reach_wr2 got n=%0d words=%0d want <100/2", n, words); end
      #2 rst_n = 1'b0;
      #1;
      vecs++; if ({cyc, stb, we, busy} !== 4'b0) begin errs++; $display("FAIL rst_async got %b want 0000", {cyc, stb, we, busy}); end
      vecs++; if (words !== 6'd0) begin errs++; $display("FAIL rst_words got %0d want 0", words); end
      @(negedge clk); rst_n = 1'b1;
      run_sweep(-1, -1, n, e0);
      vecs++; if (n !== 16 || log_adr.size() !== 8 || log_adr[0] !== BASE) begin errs++; $display("FAIL rst_restart got n=%0d txns=%0d want 16/8 from %h", n, log_adr.size(), BASE); end
      @(negedge clk);
   endtask

   initial begin
      vecs = 0; errs = 0; waits = 0; unstable = 0;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; noack = 1'b0; spurious = 1'b0;
      test_reset;
      test_sweep;
      test_wait_states;
      test_timeout;
      test_stop;
      test_noise;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/wb_scrub_master.md
WB_SCRUB_MASTER -- requirements
Module: wb_scrub_master

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data width.
REQ-002 SHALL have parameter REGISTERS, default 32, words per sweep.
REQ-003 SHALL have parameter REGDIRSIZE, default 5, word index width.
REQ-004 SHALL have parameter WHISBONE_ADR, default 32, address width.
REQ-005 SHALL have parameter BASE_ADR, default 32'h3000_0000, byte address of word 0.
REQ-006 SHALL have parameter TIMEOUT, default 16, max cycles waiting for ack.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk_i  input  1  clock, all state on rising edge.
REQ-009 rst_ni  input  1  asynchronous active-low reset.
REQ-010 start_i  input  1  begin one scrub sweep (sampled only in IDLE).
REQ-011 stop_i  input  1  end sweep after current transaction completes.
REQ-012 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic initiator controls.
REQ-013 wbm_sel_o  output  4  byte selects, always 4'b1111 while stb high, else 0.
REQ-014 wbm_adr_o  output  WHISBONE_ADR  BASE_ADR + 4*index.
REQ-015 wbm_dat_o  output  WORD_SIZE  write data; wbm_dat_i  input  WORD_SIZE  read data.
REQ-016 wbm_ack_i  input  1  responder acknowledge.
REQ-017 busy_o  output  1  sweep in progress; done_o  output  1  one-cycle end-of-sweep pulse.
REQ-018 error_o  output  1  sticky timeout flag; words_o  output  REGDIRSIZE+1  words rewritten in last/current sweep.

Function
REQ-019 States SHALL be IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
REQ-020 IDLE, start_i=1: next cycle RD, index=0, words_o=0, error_o=0, busy_o=1.
REQ-021 RD: cyc=stb=1, we=0, adr for index; held stable until ack sampled high.
REQ-022 RD with ack: capture wbm_dat_i into data register; next state RD_GAP.
REQ-023 RD_GAP: cyc=stb=0 for exactly one cycle; next WR.
REQ-024 WR: cyc=stb=we=1, same address, wbm_dat_o = captured word, held until ack.
REQ-025 WR with ack: words_o increments; next WR_GAP.
REQ-026 WR_GAP (one cycle, cyc=stb=0): if index=REGISTERS-1 or stop_i seen -> DONE; else index+1 -> RD.
REQ-027 stop_i SHALL be latched whenever busy; acted on only at WR_GAP (a started read-write pair always completes).
REQ-028 DONE: done_o=1 for one cycle, busy_o=0 same cycle, next IDLE.
REQ-029 Minimum sweep length with zero-wait ack: 4 cycles/word, REGISTERS*4 cycles from first RD to DONE.
REQ-030 Timeout counter SHALL clear on entering RD/WR and count each cycle stb=1 and ack=0; when it reaches TIMEOUT: drop cyc/stb next cycle, error_o=1, go DONE, words_o unchanged.
REQ-031 ack_i while stb=0 SHALL be ignored.
REQ-032 start_i while busy SHALL be ignored; start_i and stop_i together in IDLE start a sweep that ends after word 0.
REQ-033 wbm_dat_o SHALL be 0 whenever we=0.

Reset
REQ-034 rst_ni low SHALL immediately force IDLE; all outputs 0, index 0, data register 0, stop latch 0, timeout counter 0.
REQ-035 Reset mid-transaction SHALL drop cyc/stb asynchronously without waiting for ack.

Verification
REQ-036 REGISTERS=4, zero-wait responder returning 32'hA5A5_0000+index, start -> reads then writes of same values at 0x3000_0000..0x3000_000C, done_o after 16 cycles, words_o=4, error_o=0.
REQ-037 Responder inserts 3 wait states per access -> adr/we/dat stable during waits, one gap cycle between transactions, words_o=4.
REQ-038 No ack on word 2 read, TIMEOUT=16 -> cyc drops after 16 stb cycles, error_o=1, done_o pulse, words_o=2; next start clears error_o.
REQ-039 stop_i pulsed during word 1 read -> word 1 write completes, DONE, words_o=2, no word 2 access.
REQ-040 rst_ni low during WR with stb high -> cyc/stb/we low immediately, busy_o=0, words_o=0; start after release begins at index 0.
REQ-041 start_i pulsed mid-sweep and spurious ack in gap cycle -> no effect on sequence or words_o.
